// File: rtl/tile_write_scheduler.sv
// ---------------------------------------------------------------------------
// TileWriteScheduler (module tile_write_scheduler)
//
// Purpose:
//   Owns the single write port of the video tile-position map. Two sources
//   compete for it:
//     - CPU single writes, buffered in a small FIFO.
//     - An internal fill engine that sweeps every map position with one tile
//       value, used for screen clear or fill.
//   Every issued write appears on TilesControlRegister as {position, tile},
//   together with a one-cycle TilesWriteStrobe.
//
// Ports:
//   CLK                  system clock (same domain as the video master clock)
//   Reset                asynchronous, active-low reset
//   WrValid / WrReady    CPU write handshake
//   WrPosition, WrTile   CPU write payload
//   FillStart, FillTile  start a fill with the given tile (level sampled)
//   FillBusy             fill in progress
//   TilesControlRegister {position, tile} issued to the video block
//   TilesWriteStrobe     one-cycle pulse marking a new issued word
//   FifoCount            current FIFO occupancy
//   RangeError           sticky flag: an out-of-range CPU position was dropped
//   ErrorClear           clears RangeError (a new error in the same cycle wins)
//   InBlank              display blanking window (optional feature only)
//
// Optional feature (macro TILE_WRITE_VBLANK_GATE_EN):
//   When defined, FIFO pops and fill steps only happen on InBlank=1 cycles;
//   a fill pauses with its counter held while InBlank=0. When undefined,
//   InBlank is ignored.
// ---------------------------------------------------------------------------
module tile_write_scheduler #(
   parameter int FIFO_DEPTH    = 8,
   parameter int NUM_POSITIONS = 320,
   parameter int POS_W         = 9,
   parameter int TILE_W        = 5
) (
   input  logic                         CLK,
   input  logic                         Reset,
   input  logic                         WrValid,
   output logic                         WrReady,
   input  logic [POS_W-1:0]             WrPosition,
   input  logic [TILE_W-1:0]            WrTile,
   input  logic                         FillStart,
   input  logic [TILE_W-1:0]            FillTile,
   output logic                         FillBusy,
   output logic [POS_W+TILE_W-1:0]      TilesControlRegister,
   output logic                         TilesWriteStrobe,
   output logic [$clog2(FIFO_DEPTH):0]  FifoCount,
   output logic                         RangeError,
   input  logic                         ErrorClear,
   input  logic                         InBlank
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WORD_W = POS_W + TILE_W;

   localparam logic [CNT_W-1:0] DEPTH_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [POS_W:0]   POS_LIMIT   = (POS_W+1)'(NUM_POSITIONS);
   localparam logic [POS_W-1:0] LAST_POS    = POS_W'(NUM_POSITIONS - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } stateT;

   stateT               state;
   stateT               stateNext;

   logic [WORD_W-1:0]   fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wrPtr;
   logic [PTR_W-1:0]    rdPtr;
   logic [CNT_W-1:0]    count;

   logic [POS_W-1:0]    fillCounter;
   logic [TILE_W-1:0]   fillTileLatched;

   logic                accept;
   logic                inRange;
   logic                push;
   logic                popEn;
   logic                fillLoad;
   logic                fillAdvance;
   logic                issueValid;
   logic [WORD_W-1:0]   issueWord;
   logic                issueSlot;

   // The handshake is judged purely on the registered occupancy, so a pop in
   // the same cycle never frees room for a push into a full FIFO.
   // Out-of-range positions still complete the handshake but are never stored.
   assign WrReady   = (count < DEPTH_COUNT);
   assign accept    = WrValid && WrReady;
   assign inRange   = ({1'b0, WrPosition} < POS_LIMIT);
   assign push      = accept && inRange;
   assign FifoCount = count;
   assign FillBusy  = (state == FILL);

   // Issue slots are either every cycle or only blanking cycles, depending
   // on whether the vertical-blank gate is built in.
`ifdef TILE_WRITE_VBLANK_GATE_EN
   assign issueSlot = InBlank;
`else
   logic unusedInBlank;
   assign unusedInBlank = InBlank;
   assign issueSlot     = 1'b1;
`endif

   // State register for the IDLE/FILL scheduler.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and issue decision. In IDLE a fill request takes priority
   // over draining, and the start cycle itself issues nothing. While filling
   // the FIFO is left alone so queued CPU writes land after the sweep and
   // override fill data.
   always_comb begin
      stateNext   = state;
      issueValid  = 1'b0;
      issueWord   = '0;
      popEn       = 1'b0;
      fillLoad    = 1'b0;
      fillAdvance = 1'b0;
      case (state)
         IDLE: begin
            if (FillStart) begin
               stateNext = FILL;
               fillLoad  = 1'b1;
            end else if ((count != '0) && issueSlot) begin
               popEn      = 1'b1;
               issueValid = 1'b1;
               issueWord  = fifoMem[rdPtr];
            end
         end
         FILL: begin
            if (issueSlot) begin
               issueValid = 1'b1;
               issueWord  = {fillCounter, fillTileLatched};
               if (fillCounter == LAST_POS) begin
                  stateNext = IDLE;
               end else begin
                  fillAdvance = 1'b1;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // FIFO storage; contents need no reset because the pointers and count
   // define which entries are valid.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifoMem[wrPtr] <= {WrPosition, WrTile};
      end
   end

   // FIFO pointers and occupancy. A simultaneous push and pop leaves the
   // count unchanged. Pointers wrap naturally because the depth is a power
   // of two.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (popEn) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({push, popEn})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Fill engine: the tile value is captured at start so later changes on
   // FillTile cannot corrupt a sweep in progress. The counter holds while a
   // step is not allowed.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         fillCounter     <= '0;
         fillTileLatched <= '0;
      end else if (fillLoad) begin
         fillCounter     <= '0;
         fillTileLatched <= FillTile;
      end else if (fillAdvance) begin
         fillCounter     <= fillCounter + 1'b1;
      end
   end

   // Output word holds its last value between writes; only the strobe marks
   // new data.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         TilesControlRegister <= '0;
         TilesWriteStrobe     <= 1'b0;
      end else begin
         TilesWriteStrobe <= issueValid;
         if (issueValid) begin
            TilesControlRegister <= issueWord;
         end
      end
   end

   // Sticky range-error flag; a new error beats a clear in the same cycle.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         RangeError <= 1'b0;
      end else if (accept && !inRange) begin
         RangeError <= 1'b1;
      end else if (ErrorClear) begin
         RangeError <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tile_write_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for tile_write_scheduler.
// A queue-based reference model predicts every output on every cycle; the
// directed sections add hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_tile_write_scheduler;

   localparam int FIFO_DEPTH    = 8;
   localparam int NUM_POSITIONS = 320;
   localparam int POS_W         = 9;
   localparam int TILE_W        = 5;
   localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;
   localparam int WORD_W        = POS_W + TILE_W;

   logic                 CLK = 1'b0;
   logic                 Reset = 1'b0;
   logic                 WrValid = 1'b0;
   logic                 WrReady;
   logic [POS_W-1:0]     WrPosition = '0;
   logic [TILE_W-1:0]    WrTile = '0;
   logic                 FillStart = 1'b0;
   logic [TILE_W-1:0]    FillTile = '0;
   logic                 FillBusy;
   logic [WORD_W-1:0]    TilesControlRegister;
   logic                 TilesWriteStrobe;
   logic [CNT_W-1:0]     FifoCount;
   logic                 RangeError;
   logic                 ErrorClear = 1'b0;
   logic                 InBlank = 1'b1;

   int testsRun = 0;
   int testsFailed = 0;

   tile_write_scheduler #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .NUM_POSITIONS(NUM_POSITIONS),
      .POS_W(POS_W),
      .TILE_W(TILE_W)
   ) dut (
      .CLK(CLK),
      .Reset(Reset),
      .WrValid(WrValid),
      .WrReady(WrReady),
      .WrPosition(WrPosition),
      .WrTile(WrTile),
      .FillStart(FillStart),
      .FillTile(FillTile),
      .FillBusy(FillBusy),
      .TilesControlRegister(TilesControlRegister),
      .TilesWriteStrobe(TilesWriteStrobe),
      .FifoCount(FifoCount),
      .RangeError(RangeError),
      .ErrorClear(ErrorClear),
      .InBlank(InBlank)
   );

   always #5 CLK = ~CLK;

   // Reference model: a queue of pending CPU words, a fill position and a
   // few flags. Each clock edge applies the scheduling rules in priority
   // order: an active fill steps, else a fill request starts, else the
   // oldest queued word is issued. New CPU words join after the issue.
   logic [WORD_W-1:0] modelQueue [$];
   logic [WORD_W-1:0] modelCtrl = '0;
   logic              modelStrobe = 1'b0;
   logic              modelBusy = 1'b0;
   logic              modelErr = 1'b0;
   int                modelFillPos = 0;
   logic [TILE_W-1:0] modelFillTile = '0;

   always @(posedge CLK or negedge Reset) begin : referenceModel
      logic ready;
      logic gateOk;
      if (!Reset) begin
         modelQueue.delete();
         modelCtrl    = '0;
         modelStrobe  = 1'b0;
         modelBusy    = 1'b0;
         modelErr     = 1'b0;
         modelFillPos = 0;
      end else begin
`ifdef TILE_WRITE_VBLANK_GATE_EN
         gateOk = InBlank;
`else
         gateOk = 1'b1;
`endif
         ready       = (modelQueue.size() < FIFO_DEPTH);
         modelStrobe = 1'b0;
         if (modelBusy) begin
            if (gateOk) begin
               modelCtrl   = {POS_W'(modelFillPos), modelFillTile};
               modelStrobe = 1'b1;
               if (modelFillPos == NUM_POSITIONS - 1) modelBusy = 1'b0;
               else modelFillPos = modelFillPos + 1;
            end
         end else if (FillStart) begin
            modelBusy     = 1'b1;
            modelFillPos  = 0;
            modelFillTile = FillTile;
         end else if (modelQueue.size() > 0 && gateOk) begin
            modelCtrl   = modelQueue.pop_front();
            modelStrobe = 1'b1;
         end
         if (WrValid && ready && (int'(WrPosition) >= NUM_POSITIONS)) modelErr = 1'b1;
         else if (ErrorClear) modelErr = 1'b0;
         if (WrValid && ready && (int'(WrPosition) < NUM_POSITIONS))
            modelQueue.push_back({WrPosition, WrTile});
      end
   end

   // Per-cycle comparison of every output against the model, away from
   // the active edge.
   always @(negedge CLK) begin : compareProcess
      logic [WORD_W+CNT_W+3:0] actualBundle;
      logic [WORD_W+CNT_W+3:0] requiredBundle;
      actualBundle   = {TilesControlRegister, TilesWriteStrobe, FillBusy,
                        FifoCount, WrReady, RangeError};
      requiredBundle = {modelCtrl, modelStrobe, modelBusy,
                        CNT_W'(modelQueue.size()),
                        (modelQueue.size() < FIFO_DEPTH), modelErr};
      testsRun++;
      if (actualBundle !== requiredBundle) begin
         testsFailed++;
         $display("[TB] FAIL cycleCompare t=%0t actual=%h required=%h {ctrl,strobe,busy,count,ready,err}",
                  $time, actualBundle, requiredBundle);
      end
   end

   task automatic checkOutput(input string name, input int actual, input int required);
      testsRun++;
      if (actual !== required) begin
         testsFailed++;
         $display("[TB] FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)",
                  name, actual, actual, required, required);
      end
   endtask

   task automatic applyStimulus(input logic valid, input int pos, input int tile,
                                input logic fillStart, input int fillTile,
                                input logic errClear);
      WrValid    = valid;
      WrPosition = POS_W'(pos);
      WrTile     = TILE_W'(tile);
      FillStart  = fillStart;
      FillTile   = TILE_W'(fillTile);
      ErrorClear = errClear;
      @(negedge CLK);
   endtask

   initial begin : mainSequence
      int seen;
      int busyCycles;
      int posErrors;
      int strobes;
      logic readyAtNinth;
      logic found;
      logic [WORD_W-1:0] expWord;

      // Reset values
      repeat (3) @(negedge CLK);
      checkOutput("resetCtrl", TilesControlRegister, 0);
      checkOutput("resetStrobe", TilesWriteStrobe, 0);
      checkOutput("resetBusy", FillBusy, 0);
      checkOutput("resetCount", FifoCount, 0);
      checkOutput("resetErr", RangeError, 0);
      checkOutput("resetReady", WrReady, 1);
      Reset = 1'b1;
      repeat (5) @(negedge CLK);

      // Single CPU write issues one edge after acceptance
      applyStimulus(1'b1, 5, 3, 1'b0, 0, 1'b0);
      checkOutput("singleCountAfterAccept", FifoCount, 1);
      checkOutput("singleNoStrobeYet", TilesWriteStrobe, 0);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
      checkOutput("singleCtrl", TilesControlRegister, 14'h0A3);
      checkOutput("singleStrobe", TilesWriteStrobe, 1);
      checkOutput("singleCountDrained", FifoCount, 0);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
      checkOutput("singleStrobeDrops", TilesWriteStrobe, 0);
      checkOutput("singleCtrlHolds", TilesControlRegister, 14'h0A3);

      // Full fill with tile 7, with 9 CPU writes pushed mid-fill
      FillTile  = 5'd7;
      FillStart = 1'b1;
      @(negedge CLK);
      FillStart = 1'b0;
      seen = 0; busyCycles = 0; posErrors = 0; readyAtNinth = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (TilesWriteStrobe && seen < NUM_POSITIONS) begin
            expWord = {POS_W'(seen), 5'd7};
            if (TilesControlRegister !== expWord) posErrors++;
            seen++;
         end
         if (FillBusy) busyCycles++;
         else break;
         if (i >= 10 && i <= 18) begin
            WrValid    = 1'b1;
            WrPosition = POS_W'(100 + i);
            WrTile     = TILE_W'(i);
            if (i == 18) readyAtNinth = WrReady;
         end else begin
            WrValid = 1'b0;
         end
         @(negedge CLK);
      end
      WrValid = 1'b0;
      checkOutput("fillStrobeCount", seen, 320);
      checkOutput("fillPositionErrors", posErrors, 0);
      checkOutput("fillBusyCycles", busyCycles, 320);
      checkOutput("fifoFullReady", readyAtNinth, 0);
      checkOutput("fifoCountAfterFill", FifoCount, 8);
      for (int j = 0; j < 8; j++) begin
         @(negedge CLK);
         checkOutput($sformatf("drainStrobe%0d", j), TilesWriteStrobe, 1);
         checkOutput($sformatf("drainWord%0d", j), TilesControlRegister,
                     int'({POS_W'(110 + j), TILE_W'(10 + j)}));
      end
      @(negedge CLK);
      checkOutput("drainDoneStrobe", TilesWriteStrobe, 0);
      checkOutput("drainDoneCount", FifoCount, 0);

      // Range error: sticky, clearable, set wins over clear
      applyStimulus(1'b1, 320, 1, 1'b0, 0, 1'b0);
      checkOutput("rangeNoStore", FifoCount, 0);
      checkOutput("rangeErrSet", RangeError, 1);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);
      checkOutput("rangeNoStrobe", TilesWriteStrobe, 0);
      checkOutput("rangeErrHeld", RangeError, 1);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1);
      checkOutput("rangeErrCleared", RangeError, 0);
      applyStimulus(1'b1, 400, 2, 1'b0, 0, 1'b1);
      checkOutput("rangeSetBeatsClear", RangeError, 1);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0);

      // Push and pop in one cycle, then fill wins over a non-empty FIFO
      applyStimulus(1'b1, 20, 1, 1'b0, 0, 1'b0);
      applyStimulus(1'b1, 21, 2, 1'b0, 0, 1'b0);
      checkOutput("pushPopCount", FifoCount, 1);
      checkOutput("pushPopWord", TilesControlRegister, int'({9'd20, 5'd1}));
      applyStimulus(1'b0, 0, 0, 1'b1, 2, 1'b0);
      FillStart = 1'b0;
      checkOutput("fillWinsBusy", FillBusy, 1);
      checkOutput("fillWinsCount", FifoCount, 1);
      checkOutput("fillWinsNoStrobe", TilesWriteStrobe, 0);

      // Reset in the middle of the fill at position 100
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (TilesWriteStrobe && TilesControlRegister[WORD_W-1:TILE_W] == 9'd100) begin
            found = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      checkOutput("reachedPos100", found, 1);
      #1 Reset = 1'b0;
      #1;
      checkOutput("midResetCtrl", TilesControlRegister, 0);
      checkOutput("midResetStrobe", TilesWriteStrobe, 0);
      checkOutput("midResetBusy", FillBusy, 0);
      checkOutput("midResetCount", FifoCount, 0);
      @(negedge CLK);
      Reset = 1'b1;
      strobes = 0;
      repeat (20) begin
         @(negedge CLK);
         if (TilesWriteStrobe) strobes++;
      end
      checkOutput("quietAfterReset", strobes, 0);

      // Fill with InBlank toggling 4 cycles on / 4 off
      FillTile  = 5'd9;
      FillStart = 1'b1;
      @(negedge CLK);
      FillStart = 1'b0;
      seen = 0; busyCycles = 0; posErrors = 0;
      for (int i = 0; i < 800; i++) begin
         if (TilesWriteStrobe && seen < NUM_POSITIONS) begin
            expWord = {POS_W'(seen), 5'd9};
            if (TilesControlRegister !== expWord) posErrors++;
            seen++;
         end
         if (FillBusy) busyCycles++;
         else break;
         InBlank = ((i / 4) % 2 == 0);
         @(negedge CLK);
      end
      InBlank = 1'b1;
      checkOutput("gatedFillStrobes", seen, 320);
      checkOutput("gatedFillPosErrors", posErrors, 0);
`ifdef TILE_WRITE_VBLANK_GATE_EN
      checkOutput("gatedFillDuration", (busyCycles >= 630 && busyCycles <= 645), 1);
`else
      checkOutput("ungatedFillDuration", busyCycles, 320);
`endif
      repeat (3) @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/tile_write_scheduler.md
Name: tile_write_scheduler

Overview:
- Sequences all updates of the video tile-position map, which holds 320 entries, each a 5-bit tile index.
- Two sources share the single position-write port:
  - CPU single writes, buffered in a FIFO.
  - An internal fill engine that sweeps every position with one tile value, for screen clear or fill.
- Drives the 14-bit tile control word: position in bits [13:5], tile in bits [4:0]. Also drives a one-cycle write strobe.
- Sits between the processor bus glue and the video peripheral, in the same clock domain as the video master clock.

Parameters:
- FIFO_DEPTH, 8: CPU write FIFO entries. Must be a power of 2, at least 2.
- NUM_POSITIONS, 320: number of map entries swept by a fill.
- POS_W, 9: position field width.
- TILE_W, 5: tile field width.

Ports:
- CLK  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- WrValid  in  1  CPU write request.
- WrReady  out  1  FIFO can accept an entry.
- WrPosition  in  POS_W  map position for the CPU write.
- WrTile  in  TILE_W  tile index for the CPU write.
- FillStart  in  1  start a fill; level sampled each cycle.
- FillTile  in  TILE_W  tile value used by the fill.
- FillBusy  out  1  fill in progress.
- TilesControlRegister  out  POS_W+TILE_W  {position, tile} issued to the video block.
- TilesWriteStrobe  out  1  one-cycle pulse marking a new issued word.
- FifoCount  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- RangeError  out  1  sticky flag: a position >= NUM_POSITIONS was rejected.
- ErrorClear  in  1  clears RangeError.
- InBlank  in  1  display blanking window; used only with the optional feature.

Behaviour:
- Reset values (async, Reset=0):
  - TilesControlRegister=0, TilesWriteStrobe=0, FillBusy=0, FifoCount=0, RangeError=0.
  - FSM=IDLE, fill counter=0, FIFO pointers=0.
  - WrReady=1 once Reset is released.
  - A reset during a fill aborts the fill and flushes the FIFO.
- CPU handshake:
  - An entry is accepted on a rising edge when WrValid=1 and WrReady=1.
  - WrReady = (FifoCount < FIFO_DEPTH), computed from the registered count only. When full, no push occurs even if a pop happens in the same cycle.
  - Range check at accept time: if WrPosition >= NUM_POSITIONS, the entry is not stored, RangeError is set, and the handshake still completes.
  - Error flag: ErrorClear=1 clears RangeError. If clear and a new error occur in the same cycle, set wins.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop one entry per cycle. The popped word is registered onto TilesControlRegister with TilesWriteStrobe=1 in the same edge.
  - IDLE, minimum latency: with an empty FIFO, an entry accepted at edge N is issued at edge N+1.
  - IDLE, start condition: FillStart=1 at edge N moves the FSM to FILL. FillTile is latched and the counter is set to 0. There is no FIFO pop at edge N.
  - FILL: each edge issues {counter, latched tile} with strobe=1, then increments the counter.
  - FILL, end condition: at the edge issuing NUM_POSITIONS-1, return to IDLE. Edges N+1..N+NUM_POSITIONS issue positions 0..NUM_POSITIONS-1.
  - FILL, CPU traffic: CPU writes are still accepted into the FIFO but are not drained until the fill ends, so they override fill data. Draining resumes at edge N+NUM_POSITIONS+1.
  - FillStart while in FILL is ignored; a fill is never restarted.
- FillBusy: equals (FSM==FILL), so it is high from edge N until edge N+NUM_POSITIONS.
- Simultaneous events:
  - FillStart with a non-empty FIFO in IDLE: the fill wins, and the FIFO retains its entries.
  - A push and a pop in the same cycle leave FifoCount unchanged.
- Idle output:
  - TilesControlRegister holds its last value between writes; only the strobe marks new data.
  - The strobe is 0 on every cycle without an issue.

Optional Feature:
- Macro: TILE_WRITE_VBLANK_GATE_EN.
- When defined:
  - Issues happen only on cycles with InBlank=1. This covers both FIFO pops and fill steps.
  - A fill pauses while InBlank=0, holding its counter, and FillBusy stays 1.
  - The FIFO continues accepting entries.
- When undefined: InBlank is ignored (port kept, unused) and issue timing is as above.

Test Plan:
- Reset then a CPU write {pos=5, tile=3} at edge 10 -> at edge 11 TilesControlRegister=14'h0A3 and strobe=1 for one cycle; FifoCount returns to 0.
- FillStart=1 with FillTile=7 -> 320 strobes, positions 0..319 each with tile 7, consecutive; FillBusy high for exactly 320 cycles.
- During the fill, push 9 writes with FIFO_DEPTH=8 -> first 8 accepted, WrReady=0 on the 9th. After the fill they issue in order on 8 consecutive cycles.
- Write with WrPosition=320 -> no strobe, RangeError=1 and held. ErrorClear -> 0. Error plus clear in the same cycle -> 1.
- Assert Reset at fill position 100 -> outputs return to reset values at once. After release, no further strobes occur without a new request.
- With TILE_WRITE_VBLANK_GATE_EN and InBlank toggling 4 cycles on / 4 off -> the fill completes in 640 cycles, with strobes only on InBlank=1 cycles and no skipped or repeated positions.
